// File: rtl/ir_stream_loader.sv
// Byte-stream loader for the impulse-response buffer: hunts for a sync byte,
// assembles little-endian signed 16-bit samples and writes them out indexed.
module ir_stream_loader #(
   parameter int unsigned IMPULSE_LENGTH = 24000,
   parameter int unsigned INDEX_WIDTH    = 16,
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                   audio_clk,
   input  logic                   rst_in,
   input  logic                   start_in,
   input  logic [7:0]             byte_in,
   input  logic                   byte_valid_in,
   output logic [INDEX_WIDTH-1:0] ir_sample_index,
   output logic signed [15:0]     write_data,
   output logic                   write_enable,
   output logic                   ir_data_in_valid,
   output logic                   impulse_in_memory_complete,
   output logic                   load_error,
   output logic                   busy
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {IDLE, WAIT_SYNC, LOW_BYTE, HIGH_BYTE, DONE, ERROR} state_t;

   state_t                 state;
   logic [INDEX_WIDTH-1:0] sample_cnt;
   logic [7:0]             low_latch;
   logic [TW-1:0]          tmo_cnt;

   always_ff @(posedge audio_clk or posedge rst_in) begin
      if (rst_in) begin
         state                      <= IDLE;
         sample_cnt                 <= '0;
         low_latch                  <= '0;
         tmo_cnt                    <= '0;
         ir_sample_index            <= '0;
         write_data                 <= '0;
         write_enable               <= 1'b0;
         ir_data_in_valid           <= 1'b0;
         impulse_in_memory_complete <= 1'b0;
         load_error                 <= 1'b0;
         busy                       <= 1'b0;
      end else begin
         ir_data_in_valid <= 1'b0;
         if (start_in) begin
            // start overrides whatever byte arrives in the same cycle
            state                      <= WAIT_SYNC;
            sample_cnt                 <= '0;
            low_latch                  <= '0;
            tmo_cnt                    <= '0;
            ir_sample_index            <= '0;
            write_data                 <= '0;
            write_enable               <= 1'b0;
            impulse_in_memory_complete <= 1'b0;
            load_error                 <= 1'b0;
            busy                       <= 1'b1;
         end else begin
            case (state)
               WAIT_SYNC: begin
                  if (byte_valid_in && byte_in == SYNC_BYTE) begin
                     state        <= LOW_BYTE;
                     write_enable <= 1'b1;
                     tmo_cnt      <= '0;
                  end
               end
               LOW_BYTE, HIGH_BYTE: begin
                  if (byte_valid_in) begin
                     tmo_cnt <= '0;
                     if (state == LOW_BYTE) begin
                        low_latch <= byte_in;
                        state     <= HIGH_BYTE;
                     end else begin
                        write_data       <= $signed({byte_in, low_latch});
                        ir_sample_index  <= sample_cnt;
                        ir_data_in_valid <= 1'b1;
                        sample_cnt       <= sample_cnt + INDEX_WIDTH'(1);
                        if (sample_cnt == INDEX_WIDTH'(IMPULSE_LENGTH - 1)) begin
                           state                      <= DONE;
                           write_enable               <= 1'b0;
                           impulse_in_memory_complete <= 1'b1;
                           busy                       <= 1'b0;
                        end else begin
                           state <= LOW_BYTE;
                        end
                     end
                  end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                     // TIMEOUT_CYCLES consecutive idle cycles abort the load
                     state        <= ERROR;
                     load_error   <= 1'b1;
                     write_enable <= 1'b0;
                     busy         <= 1'b0;
                  end else begin
                     tmo_cnt <= tmo_cnt + TW'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ir_stream_loader.sv
// Directed bench for ir_stream_loader: small instance (4 samples, timeout 16)
// for protocol cases and a default-size instance for the full-rate stream.
module tb_ir_stream_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b0;

   logic        s_start = 1'b0, s_vld = 1'b0;
   logic [7:0]  s_byte  = '0;
   logic [15:0] s_idx, s_wd;
   logic        s_we, s_valid, s_cmp, s_err, s_busy;

   logic        l_start = 1'b0, l_vld = 1'b0;
   logic [7:0]  l_byte  = '0;
   logic [15:0] l_idx, l_wd;
   logic        l_we, l_valid, l_cmp, l_err, l_busy;

   ir_stream_loader #(.IMPULSE_LENGTH(4), .TIMEOUT_CYCLES(16)) dut_s (
      .audio_clk(clk), .rst_in(rst), .start_in(s_start), .byte_in(s_byte),
      .byte_valid_in(s_vld), .ir_sample_index(s_idx), .write_data(s_wd),
      .write_enable(s_we), .ir_data_in_valid(s_valid),
      .impulse_in_memory_complete(s_cmp), .load_error(s_err), .busy(s_busy));

   ir_stream_loader dut_l (
      .audio_clk(clk), .rst_in(rst), .start_in(l_start), .byte_in(l_byte),
      .byte_valid_in(l_vld), .ir_sample_index(l_idx), .write_data(l_wd),
      .write_enable(l_we), .ir_data_in_valid(l_valid),
      .impulse_in_memory_complete(l_cmp), .load_error(l_err), .busy(l_busy));

   int n_assert = 0;
   int n_fail   = 0;

   logic [31:0] q_s[$];
   logic [31:0] q_l[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // scoreboard for the small instance; also flags strobes wider than one cycle
   logic s_prev = 1'b0;
   always @(negedge clk) begin
      if (s_valid) begin
         check("s_strobe_width", {31'b0, s_prev}, 32'd0);
         check("s_queue_nonempty", {31'b0, q_s.size() != 0}, 32'd1);
         if (q_s.size() != 0) check("s_idx_data", {s_idx, s_wd}, q_s.pop_front());
      end
      s_prev = s_valid;
   end

   int cyc = 0, l_last = 0, l_cnt = 0;
   always @(negedge clk) begin
      cyc++;
      if (l_valid) begin
         check("l_queue_nonempty", {31'b0, q_l.size() != 0}, 32'd1);
         if (q_l.size() != 0) check("l_idx_data", {l_idx, l_wd}, q_l.pop_front());
         if (l_cnt > 0) check("l_strobe_gap", cyc - l_last, 32'd2);
         l_last = cyc;
         l_cnt++;
      end
   end

   task automatic s_pulse_start(input logic with_byte);
      s_start = 1'b1;
      s_vld   = with_byte;
      s_byte  = 8'h99;
      @(negedge clk);
      s_start = 1'b0;
      s_vld   = 1'b0;
   endtask

   task automatic s_send(input logic [7:0] b, input logic exp_strobe);
      s_byte = b;
      s_vld  = 1'b1;
      @(negedge clk);
      check("s_strobe_latency", {31'b0, s_valid}, {31'b0, exp_strobe});
   endtask

   task automatic s_sample(input logic [15:0] idx, input logic [15:0] d);
      q_s.push_back({idx, d});
      s_send(d[7:0], 1'b0);
      s_send(d[15:8], 1'b1);
   endtask

   task automatic s_idle(input int n);
      s_vld = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic s_outputs_zero(input string tag);
      check(tag, {s_idx, s_wd}, 32'd0);
      check(tag, {27'b0, s_we, s_valid, s_cmp, s_err, s_busy}, 32'd0);
   endtask

   initial begin
      // power-on reset, asynchronous
      @(negedge clk);
      rst = 1'b1;
      #1;
      s_outputs_zero("reset_outputs");
      check("l_reset_outputs", {27'b0, l_we, l_valid, l_cmp, l_err, l_busy}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // nominal load
      s_pulse_start(1'b0);
      check("start_busy_we", {30'b0, s_busy, s_we}, 32'b10);
      s_send(8'hA5, 1'b0);
      check("sync_we", {30'b0, s_busy, s_we}, 32'b11);
      s_sample(16'd0, 16'h1234);
      s_sample(16'd1, 16'hFFFE);
      s_sample(16'd2, 16'h8000);
      check("nom_not_complete", {31'b0, s_cmp}, 32'd0);
      s_sample(16'd3, 16'h7FFF);
      check("nom_done_flags", {29'b0, s_cmp, s_we, s_busy}, 32'b100);
      s_idle(1);
      check("nom_hold", {s_idx, s_wd}, {16'd3, 16'h7FFF});
      s_send(8'hA5, 1'b0);
      s_send(8'h01, 1'b0);
      s_send(8'h02, 1'b0);
      s_idle(1);
      check("done_holds", {29'b0, s_cmp, s_we, s_busy}, 32'b100);

      // sync hunt
      s_pulse_start(1'b0);
      check("start_clears_complete", {31'b0, s_cmp}, 32'd0);
      s_send(8'h00, 1'b0);
      s_send(8'h5A, 1'b0);
      s_send(8'hFF, 1'b0);
      check("hunt_no_we", {31'b0, s_we}, 32'd0);
      s_send(8'hA5, 1'b0);
      s_sample(16'd0, 16'h0001);

      // timeout
      s_pulse_start(1'b0);
      s_send(8'hA5, 1'b0);
      s_send(8'h11, 1'b0);
      s_idle(15);
      check("tmo_not_yet", {30'b0, s_err, s_busy}, 32'b01);
      s_idle(1);
      check("tmo_error", {28'b0, s_err, s_busy, s_cmp, s_we}, 32'b1000);
      s_idle(3);
      check("error_holds", {31'b0, s_err}, 32'd1);
      s_pulse_start(1'b0);
      check("start_clears_error", {30'b0, s_err, s_busy}, 32'b01);

      // restart mid-load with a colliding byte
      s_send(8'hA5, 1'b0);
      s_sample(16'd0, 16'h0102);
      s_sample(16'd1, 16'h0304);
      s_send(8'h55, 1'b0);
      s_pulse_start(1'b1);
      check("restart_state", {30'b0, s_busy, s_we}, 32'b10);
      s_send(8'hA5, 1'b0);
      s_sample(16'd0, 16'hA1B2);
      s_sample(16'd1, 16'hC3D4);
      s_sample(16'd2, 16'hE5F6);
      check("restart_not_complete", {31'b0, s_cmp}, 32'd0);
      s_sample(16'd3, 16'h0708);
      check("restart_complete", {31'b0, s_cmp}, 32'd1);
      s_idle(1);

      // reset mid-load at count 2
      s_pulse_start(1'b0);
      s_send(8'hA5, 1'b0);
      s_sample(16'd0, 16'h1111);
      s_sample(16'd1, 16'h2222);
      s_send(8'h33, 1'b0);
      s_vld = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      s_outputs_zero("midload_reset");
      @(negedge clk);
      rst = 1'b0;
      s_send(8'hA5, 1'b0);
      s_send(8'h01, 1'b0);
      s_send(8'h02, 1'b0);
      s_idle(2);
      s_outputs_zero("reset_ignores_bytes");

      // full-rate stream on the default-size instance
      l_start = 1'b1;
      @(negedge clk);
      l_start = 1'b0;
      l_byte  = 8'hA5;
      l_vld   = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 24000; i++) begin
         logic [15:0] d;
         d = 16'($urandom);
         q_l.push_back({16'(i), d});
         l_byte = d[7:0];
         @(negedge clk);
         l_byte = d[15:8];
         @(negedge clk);
      end
      l_vld = 1'b0;
      repeat (2) @(negedge clk);
      check("l_strobe_count", l_cnt, 32'd24000);
      check("l_final_flags", {28'b0, l_cmp, l_we, l_busy, l_err}, 32'b1000);
      check("l_queue_empty", q_l.size(), 32'd0);
      check("s_queue_empty", q_s.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/ir_stream_loader.md
Name: ir_stream_loader

Overview:
- Upstream feeder for the impulse-response buffer.
- Takes a byte stream from the host link receiver, waits for a sync byte, then assembles little-endian signed 16-bit IR samples.
- Drives the buffer's write port, one indexed sample per handshake pulse, and flags completion to the convolution stage once IMPULSE_LENGTH samples are stored.
- Detects stalled transfers with an inter-byte timeout.

Parameters:
- IMPULSE_LENGTH, 24000, number of IR samples per load (>=2).
- INDEX_WIDTH, 16, width of ir_sample_index.
- SYNC_BYTE, 8'hA5, byte that precedes sample data.
- TIMEOUT_CYCLES, 1_000_000, max audio_clk cycles between data bytes before abort.

Ports:
- audio_clk  in  1  system clock; all logic on rising edge.
- rst_in  in  1  asynchronous active-high reset.
- start_in  in  1  one-cycle pulse: begin/restart a load.
- byte_in  in  8  received byte.
- byte_valid_in  in  1  byte_in valid this cycle; no backpressure.
- ir_sample_index  out  INDEX_WIDTH  buffer address of write_data.
- write_data  out  16 signed  assembled sample.
- write_enable  out  1  high while a load is in progress (sync found through last sample).
- ir_data_in_valid  out  1  one-cycle strobe: write_data/ir_sample_index valid.
- impulse_in_memory_complete  out  1  level: full IR stored.
- load_error  out  1  level: last load aborted by timeout.
- busy  out  1  high in any state other than IDLE/DONE/ERROR.

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0; sample counter, low-byte latch and timeout counter 0.
- All outputs are registered.
- States: IDLE, WAIT_SYNC, LOW_BYTE, HIGH_BYTE, DONE, ERROR.
- start_in, any state:
  - next state WAIT_SYNC; counter=0.
  - complete=0, load_error=0, write_enable=0.
  - Any byte_valid_in in the same cycle is discarded; start wins.
- WAIT_SYNC:
  - byte == SYNC_BYTE -> LOW_BYTE, write_enable=1.
  - All other bytes ignored.
  - No timeout in this state.
- LOW_BYTE: on byte_valid_in, latch byte as sample[7:0] -> HIGH_BYTE.
- HIGH_BYTE: on byte_valid_in:
  - next cycle write_data = {byte_in, low_latch}, ir_sample_index = counter, ir_data_in_valid=1 for exactly that cycle.
  - Counter increments in the same cycle.
  - If the written index == IMPULSE_LENGTH-1 -> DONE; else -> LOW_BYTE.
- Latency: 1 cycle from the accepted high byte to the strobe.
- write_data/ir_sample_index hold their values until the next strobe, reset, or start.
- DONE:
  - write_enable=0 and impulse_in_memory_complete=1, both in the same cycle as the final strobe.
  - Held until start_in or reset.
  - Bytes ignored.
- Timeout (LOW_BYTE, HIGH_BYTE only):
  - counter cleared on each byte_valid_in and on entry; increments otherwise.
  - Reaching TIMEOUT_CYCLES -> ERROR: load_error=1, write_enable=0, busy=0; partial samples are not invalidated.
  - ERROR holds until start_in or reset.
- busy=1 in WAIT_SYNC, LOW_BYTE, HIGH_BYTE.
- Counter width: INDEX_WIDTH. IMPULSE_LENGTH must be <= 2^INDEX_WIDTH; counter never wraps because DONE is entered first.
- Reset mid-load: immediate IDLE; complete stays 0; a restart requires start_in.
- Back-to-back bytes every cycle: supported at full rate, one sample per 2 cycles.

Test Plan:
- Reset check: rst_in pulsed mid-load at count 2 -> all outputs 0 immediately (async), state IDLE, later bytes ignored until start_in.
- Nominal (IMPULSE_LENGTH=4): start, then bytes A5, 34,12, FE,FF, 00,80, FF,7F.
  - Strobes at indices 0..3 with data 16'h1234, 16'hFFFE (-2), 16'h8000, 16'h7FFF.
  - Each strobe is one cycle, exactly 1 cycle after its high byte.
  - complete=1 and write_enable=0 in the same cycle as the index-3 strobe.
- Sync hunt: start, then bytes 00, 5A, FF, A5, 01, 00 -> no strobe before A5; first strobe index 0, data 16'h0001.
- Timeout (TIMEOUT_CYCLES=16): after sync and one low byte, idle 16 cycles -> load_error=1, busy=0, no strobe, complete=0.
  - A following start clears load_error.
- Restart: start mid-load at index 2, with byte_valid_in asserted in the same cycle.
  - That byte is dropped; the next load begins at index 0 after a fresh A5.
  - complete is asserted only after 4 new samples.
- Full-rate stream: byte_valid_in every cycle for 1+2*IMPULSE_LENGTH bytes (default 24000) -> 24000 strobes, indices 0..23999 contiguous, strobes every 2 cycles, complete asserted.
